uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Packet-atomic arbiter that shares the single UART transmitter between two byte-stream requesters: requester 0 is the DTM escape-TX stream and requester 1 is a secondary channel such as a trace or passthrough stream. It sits between the requester byte sources and the UART `WE_I`/`DSEND_I`/`TX_READY_O` port. It grants whole packets in round-robin order and releases a stalled owner after a watchdog timeout. It can optionally insert an in-band channel-switch marker.

## Interface
Parameters:
- `ESC`, 8'hB1: escape byte used for the switch marker.
- `CMD_SW_BASE`, 8'h10: switch command base; the command byte sent is `CMD_SW_BASE | {7'b0, owner}`.
- `TIMEOUT_CYCLES`, 1024: stall cycles allowed inside a packet before the grant is revoked; 0 disables the watchdog.

Ports:
- `CLK_I` in 1: the single clock.
- `RST_NI` in 1: reset, asynchronous and active-low.
- `REQ0_VALID_I` in 1: requester 0 byte valid.
- `REQ0_DATA_I` in 8: requester 0 byte.
- `REQ0_LAST_I` in 1: requester 0 byte is the last byte of its packet.
- `REQ0_READY_O` out 1: requester 0 byte accepted.
- `REQ1_VALID_I`, `REQ1_DATA_I`, `REQ1_LAST_I`, `REQ1_READY_O`: same as requester 0, for requester 1.
- `TX_READY_I` in 1: UART can take a byte this cycle.
- `WE_O` out 1: write strobe to the UART.
- `DSEND_O` out 8: byte to the UART.
- `CHANNEL_O` out 1: current or most recent owner.
- `TIMEOUT_O` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- A transfer on the UART side happens when `WE_O` is high. `WE_O` is never high unless `TX_READY_I` is high.
- A transfer on the requester side happens when `REQx_VALID_I && REQx_READY_O`. A requester must hold valid, data and last stable until its transfer completes.
- FSM states: IDLE, MARK_ESC, MARK_CMD, STREAM.
- IDLE:
  - All ready signals are 0, `WE_O` is 0, `DSEND_O` is 8'h00.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the grant goes to the requester selected by the priority pointer `prio`. `prio` resets to 0 and is set to the opposite of the owner whenever a grant ends.
  - The grant is registered, and the FSM leaves IDLE on the next edge: to MARK_ESC when a marker is due (see Configuration), otherwise to STREAM.
- MARK_ESC: `DSEND_O` = `ESC`, `WE_O` = `TX_READY_I`. After a transfer the FSM moves to MARK_CMD.
- MARK_CMD: `DSEND_O` = `CMD_SW_BASE | owner`, `WE_O` = `TX_READY_I`. After a transfer the FSM moves to STREAM.
- STREAM, combinational passthrough from the owner:
  - `REQowner_READY_O` = `TX_READY_I`.
  - `WE_O` = `TX_READY_I && REQowner_VALID_I`.
  - `DSEND_O` = `REQowner_DATA_I`.
  - The non-owner's ready is held at 0.
  - A transfer with LAST high returns the FSM to IDLE and flips `prio`.
- Watchdog:
  - A `$clog2(TIMEOUT_CYCLES+1)`-bit counter clears on every transfer and on entry to STREAM.
  - It increments on each STREAM cycle without a transfer and saturates.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, `TIMEOUT_O` pulses, and `prio` flips.
  - The rest of the stalled packet is delivered as a new packet at that requester's next grant. The arbiter does not drop bytes.
- `CHANNEL_O` tracks the registered owner and holds it through IDLE.
- Reset values: FSM in IDLE, owner 0, `prio` 0, counter 0. Outputs: `WE_O` 0, `DSEND_O` 8'h00, both `REQx_READY_O` 0, `CHANNEL_O` 0, `TIMEOUT_O` 0.
- Reset asserted mid-packet or mid-marker aborts immediately. No byte is emitted after reset assertion.

## Timing
- Arbitration latency: 1 cycle from valid in IDLE to the first STREAM or MARK_ESC cycle.
- STREAM adds 0 cycles of latency, so a requester streaming with `TX_READY_I` continuously high transfers 1 byte per cycle.
- Packet-to-packet gap: 1 IDLE cycle, plus 2 byte slots when a marker is sent.
- A single-byte packet (valid and LAST together) is legal and returns the FSM to IDLE after one transfer.
- If `TX_READY_I` drops in the middle of a marker, the marker stalls and is not restarted.
- If the watchdog expires in the same cycle as a transfer, the transfer wins: the counter clears and there is no timeout.

## Configuration
- `UART_TX_ARB_SWITCH_MARKER_EN` defined:
  - MARK_ESC and MARK_CMD are compiled in.
  - A marker is due when the new owner differs from the previous owner. The previous owner after reset is 0.
  - A timeout-revoked grant counts as ownership, so re-granting the other requester sends a marker.
- Not defined:
  - MARK_ESC and MARK_CMD do not exist, and IDLE always goes to STREAM.
  - `ESC` and `CMD_SW_BASE` are unused.

## Test plan
- Req0 sends 3 bytes {41,42,43} with LAST on 43, `TX_READY_I`=1 -> `DSEND_O` shows 41, 42, 43 on 3 consecutive cycles starting 1 cycle after valid; FSM returns to IDLE; `CHANNEL_O`=0.
- Both requesters valid from reset with 2-byte packets -> order is req0 packet then req1 packet. With the macro defined, B1 11 is sent before the req1 bytes; `prio` ends at 0.
- `TX_READY_I` toggles 1,0,1,0 during a 4-byte req1 packet -> `WE_O` is never high while ready is 0; all 4 bytes are delivered in order; `REQ0_READY_O` stays 0.
- `TIMEOUT_CYCLES`=8, req0 sends 1 byte without LAST and then drops valid, req1 is valid -> `TIMEOUT_O` pulses 8 cycles after the byte; req1 is granted next cycle.
- `RST_NI` is asserted asynchronously in the middle of MARK_CMD -> `WE_O`=0 and both readies are 0 in the same cycle; after release, the first packet from req0 is sent without a marker.
- Two back-to-back req0 packets with the macro defined -> no marker between them; 1 IDLE cycle gap.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin share of one UART TX between two byte requesters, with stall watchdog.
// Define UART_TX_ARB_SWITCH_MARKER_EN to send an ESC/CMD channel-switch marker whenever the owner changes.
module uart_tx_arbiter #(
  parameter logic [7:0]  ESC            = 8'hB1,
  parameter logic [7:0]  CMD_SW_BASE    = 8'h10,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       REQ0_VALID_I,
  input  logic [7:0] REQ0_DATA_I,
  input  logic       REQ0_LAST_I,
  output logic       REQ0_READY_O,
  input  logic       REQ1_VALID_I,
  input  logic [7:0] REQ1_DATA_I,
  input  logic       REQ1_LAST_I,
  output logic       REQ1_READY_O,
  input  logic       TX_READY_I,
  output logic       WE_O,
  output logic [7:0] DSEND_O,
  output logic       CHANNEL_O,
  output logic       TIMEOUT_O
);
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_TX_ARB_SWITCH_MARKER_EN
  typedef enum logic [1:0] {IDLE, MARK_ESC, MARK_CMD, STREAM} state_e;
`else
  typedef enum logic {IDLE, STREAM} state_e;
  logic [15:0] unused_marker_bytes;
  assign unused_marker_bytes = {ESC, CMD_SW_BASE};
`endif
  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant, own_valid, own_last, xfer, expire;
  logic [7:0]    own_data;
  assign grant     = (REQ0_VALID_I && REQ1_VALID_I) ? prio_q : REQ1_VALID_I;
  assign own_valid = owner_q ? REQ1_VALID_I : REQ0_VALID_I;
  assign own_last  = owner_q ? REQ1_LAST_I : REQ0_LAST_I;
  assign own_data  = owner_q ? REQ1_DATA_I : REQ0_DATA_I;
  assign xfer      = (state_q == STREAM) && TX_READY_I && own_valid;
  // A transfer in the expiry cycle wins, so expiry needs a stalled cycle.
  assign expire    = (TIMEOUT_CYCLES != 0) && (state_q == STREAM) && !xfer &&
                     (({1'b0, cnt_q} + (CW+1)'(1)) == (CW+1)'(TIMEOUT_CYCLES));
  assign CHANNEL_O = owner_q;
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    prio_d       = prio_q;
    cnt_d        = '0;
    WE_O         = 1'b0;
    DSEND_O      = 8'h00;
    REQ0_READY_O = 1'b0;
    REQ1_READY_O = 1'b0;
    TIMEOUT_O    = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ0_VALID_I || REQ1_VALID_I) begin
          owner_d = grant;
`ifdef UART_TX_ARB_SWITCH_MARKER_EN
          state_d = (grant != owner_q) ? MARK_ESC : STREAM;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef UART_TX_ARB_SWITCH_MARKER_EN
      MARK_ESC: begin
        DSEND_O = ESC;
        WE_O    = TX_READY_I;
        state_d = TX_READY_I ? MARK_CMD : MARK_ESC;
      end
      MARK_CMD: begin
        DSEND_O = CMD_SW_BASE | {7'b0, owner_q};
        WE_O    = TX_READY_I;
        state_d = TX_READY_I ? STREAM : MARK_CMD;
      end
`endif
      STREAM: begin
        REQ0_READY_O = !owner_q && TX_READY_I;
        REQ1_READY_O = owner_q && TX_READY_I;
        WE_O         = xfer;
        DSEND_O      = own_data;
        TIMEOUT_O    = expire;
        cnt_d        = xfer ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CW'(1));
        if ((xfer && own_last) || expire) begin
          state_d = IDLE;
          prio_d  = !owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
